// File: rtl/stream_downsizer_pkg.sv
// stream_downsizer_pkg: shared stream widths and the downsizer FSM state type
package stream_downsizer_pkg;
  localparam int STREAM_DATA_W = 32;
  localparam int STREAM_LAST_BIT = 32;
  localparam int BYTE_W = 8;
  typedef enum logic {EMPTY = 1'b0, SERIAL = 1'b1} state_e;
endpackage

// File: rtl/stream_downsizer_if.sv
// stream_downsizer_if: valid/ready stream carrying {last, payload}
interface stream_downsizer_if #(parameter int W = 33) ();
  logic d_valid;
  logic [W-1:0] data;
  logic d_ready;
  modport master (output d_valid, data, input d_ready);
  modport slave (input d_valid, data, output d_ready);
endinterface

// File: rtl/stream_downsizer.sv
// stream_downsizer: serializes each wide input word into LSB-first narrow beats
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int IN_W = STREAM_DATA_W,
  parameter int OUT_W = BYTE_W
) (
  input logic clk,
  input logic rst,
  stream_downsizer_if.slave upstr,
  stream_downsizer_if.master downstr
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  if (IN_W % OUT_W != 0 || RATIO < 2) begin : g_bad_ratio
    $error("stream_downsizer: IN_W must be a multiple of OUT_W with ratio >= 2");
  end
  state_e state_q, state_d;
  logic [IN_W-1:0] word_q, word_d;
  logic last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic final_beat, in_fire, out_fire;
  assign final_beat = idx_q == IDX_W'(RATIO - 1);
  // Ready looks through to the consumer so a new word lands on the final beat's edge.
  assign upstr.d_ready = !rst && (state_q == EMPTY || (downstr.d_ready && final_beat));
  assign downstr.d_valid = !rst && state_q == SERIAL;
  assign downstr.data = {last_q && final_beat, word_q[idx_q*OUT_W +: OUT_W]};
  assign in_fire = upstr.d_valid && upstr.d_ready;
  assign out_fire = downstr.d_valid && downstr.d_ready;
  always_comb begin
    state_d = in_fire ? SERIAL : (out_fire && final_beat) ? EMPTY : state_q;
    word_d = in_fire ? upstr.data[IN_W-1:0] : word_q;
    last_d = in_fire ? upstr.data[IN_W] : last_q;
    idx_d = (in_fire || (out_fire && final_beat)) ? '0 : out_fire ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      word_q <= '0;
      last_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      last_q <= last_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer: directed and random scoreboard bench for stream_downsizer
module tb_stream_downsizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int in_lasts = 0;
  int out_lasts = 0;
  bit rand_phase = 1'b0;
  bit hold = 1'b0;
  logic [8:0] hold_data;
  logic [8:0] exp_q[$];
  stream_downsizer_if #(.W(33)) up ();
  stream_downsizer_if #(.W(9)) dn ();
  stream_downsizer #(.IN_W(32), .OUT_W(8)) dut (.clk(clk), .rst(rst), .upstr(up), .downstr(dn));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  // Scoreboard: each accepted word expands into its four bytes, low byte first.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dvalid", 33'(dn.d_valid), 33'd0);
      chk("rst_uready", 33'(up.d_ready), 33'd0);
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {dn.d_valid, dn.data}, {1'b1, hold_data});
      if (up.d_valid && up.d_ready) begin
        for (int i = 0; i < 4; i++)
          exp_q.push_back({i == 3 && up.data[32], 8'(up.data[31:0] >> (8 * i))});
        if (rand_phase) in_lasts += int'(up.data[32]);
      end
      if (dn.d_valid && dn.d_ready) begin
        chk("beat_expected", 33'(exp_q.size() != 0), 33'd1);
        if (exp_q.size() != 0) chk("beat", 33'(dn.data), 33'(exp_q.pop_front()));
        if (rand_phase) out_lasts += int'(dn.data[8]);
      end
      hold = dn.d_valid && !dn.d_ready;
      hold_data = dn.data;
    end
  end
  task automatic send_word(input logic [32:0] w);
    int n = 0;
    up.data = w;
    up.d_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!up.d_ready && n < 200);
    chk("send_accept", 33'(up.d_ready), 33'd1);
    @(posedge clk);
    #1 up.d_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((dn.d_valid || exp_q.size() != 0) && n < 100);
    chk("idle", 33'(dn.d_valid), 33'd0);
    @(posedge clk);
    #1;
  endtask
  logic [8:0] b2b[8] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h107};
  logic [8:0] single[4] = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
  initial begin
    int n;
    bit done;
    up.d_valid = 1'b1;
    up.data = 33'h1_DDCC_BBAA;
    dn.d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    up.d_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_uready", 33'(up.d_ready), 33'd1);
    @(posedge clk);
    #1;
    send_word(33'h1_DDCC_BBAA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_valid", 33'(dn.d_valid), 33'd1);
      chk("single_beat", 33'(dn.data), 33'(single[i]));
    end
    @(negedge clk);
    chk("single_done", 33'(dn.d_valid), 33'd0);
    wait_idle();
    up.data = 33'h0_0302_0100;
    up.d_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!up.d_ready && n < 100);
    chk("b2b_accept0", 33'(up.d_ready), 33'd1);
    @(posedge clk);
    #1 up.data = 33'h1_0706_0504;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_valid", 33'(dn.d_valid), 33'd1);
      chk("b2b_beat", 33'(dn.data), 33'(b2b[i]));
      chk("b2b_uready", 33'(up.d_ready), 33'(i % 4 == 3));
      if (i == 3) begin
        @(posedge clk);
        #1 up.d_valid = 1'b0;
      end
    end
    wait_idle();
    send_word(33'h0_4433_2211);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 dn.d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 33'(dn.d_valid), 33'd1);
      chk("bp_beat", 33'(dn.data), 33'h033);
      chk("bp_uready", 33'(up.d_ready), 33'd0);
    end
    @(posedge clk);
    #1 dn.d_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 33'(dn.data), 33'h033);
    @(negedge clk);
    chk("bp_resume", 33'(dn.data), 33'h044);
    wait_idle();
    send_word(33'h1_DDCC_BBAA);
    @(negedge clk);
    chk("mid_first", 33'(dn.data), 33'h0AA);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 33'(dn.d_valid), 33'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_empty", 33'(dn.d_valid), 33'd0);
    chk("mid_uready", 33'(up.d_ready), 33'd1);
    @(posedge clk);
    #1;
    send_word(33'h0_1234_5678);
    @(negedge clk);
    chk("mid_next", 33'(dn.data), 33'h078);
    wait_idle();
    rand_phase = 1'b1;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_word({1'($urandom_range(0, 1)), 32'($urandom)});
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 dn.d_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    dn.d_ready = 1'b1;
    wait_idle();
    chk("drain", 33'(exp_q.size()), 33'd0);
    chk("last_count", 33'(out_lasts), 33'(in_lasts));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
